// File: rtl/multi_edge_pulse_pkg.sv
// Shared types and limits for the multi-channel edge-to-pulse block.
package multi_edge_pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int unsigned MAX_CH          = 32;
  localparam int unsigned MAX_SYNC_STAGES = 4;

  // Select which raw edge events count for a given channel mode.
  function automatic logic qualify_edge(input edge_mode_t mode, input logic rise,
                                        input logic fall);
    logic q;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_pulse_ch.sv
// One channel: synchroniser, edge detect, stretch counter, sticky/overrun flags.
module edge_pulse_ch
  import multi_edge_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEN_W       = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             level_i,
  input  edge_mode_t       mode_i,
  input  logic [LEN_W-1:0] pulse_len_i,
  input  logic             sticky_clr_i,
  output logic             pulse_o,
  output logic             sticky_o,
  output logic             overrun_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   sticky_q, sticky_d;
  logic                   overrun_q, overrun_d;
  logic                   s_last;
  logic                   rise_ev, fall_ev, qual_ev, busy;

  // Edge events come from the last sync stage against its one-cycle history;
  // these run regardless of mode so a mode change cannot fake an edge.
  assign s_last  = sync_q[SYNC_STAGES-1];
  assign rise_ev = s_last & ~hist_q;
  assign fall_ev = ~s_last & hist_q;
  assign qual_ev = qualify_edge(mode_i, rise_ev, fall_ev);
  assign busy    = (cnt_q != '0);

  // Pulse is combinational so it appears in the same cycle as the edge.
  assign pulse_o   = qual_ev | busy;
  assign sticky_o  = sticky_q;
  assign overrun_o = overrun_q;

  // Next-state: shift synchroniser, load/decrement counter, set-wins flags.
  always_comb begin
    sync_d    = '0;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    overrun_d = overrun_q;

    sync_d[0] = level_i;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end

    if (qual_ev) begin
      cnt_d = pulse_len_i;
    end else if (busy) begin
      cnt_d = cnt_q - LEN_W'(1);
    end

    if (sticky_clr_i) begin
      sticky_d  = 1'b0;
      overrun_d = 1'b0;
    end
    if (qual_ev) begin
      sticky_d = 1'b1;
    end
    if (qual_ev && busy) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= s_last;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/multi_edge_pulse.sv
// Multi-channel edge-to-pulse stretcher: parameter checks plus one channel per bit.
module multi_edge_pulse
  import multi_edge_pulse_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEN_W       = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_CH-1:0]      level,
  input  logic [NUM_CH-1:0][1:0] mode,
  input  logic [LEN_W-1:0]       pulse_len,
  input  logic [NUM_CH-1:0]      sticky_clr,
  output logic [NUM_CH-1:0]      pulse,
  output logic [NUM_CH-1:0]      sticky,
  output logic [NUM_CH-1:0]      overrun
);

  // Reject illegal configurations at elaboration.
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("multi_edge_pulse: NUM_CH must be 1..32");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("multi_edge_pulse: SYNC_STAGES must be 1..4");
  end
  if (LEN_W < 1) begin : g_bad_len_w
    $error("multi_edge_pulse: LEN_W must be at least 1");
  end

  // Independent channel instances.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    edge_pulse_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .LEN_W      (LEN_W)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .level_i     (level[g]),
      .mode_i      (edge_mode_t'(mode[g])),
      .pulse_len_i (pulse_len),
      .sticky_clr_i(sticky_clr[g]),
      .pulse_o     (pulse[g]),
      .sticky_o    (sticky[g]),
      .overrun_o   (overrun[g])
    );
  end

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Directed bench for multi_edge_pulse with default parameters.
module tb_multi_edge_pulse;
  import multi_edge_pulse_pkg::*;

  logic           clock;
  logic           reset_n;
  logic [3:0]     level;
  logic [3:0][1:0] mode;
  logic [3:0]     pulse_len;
  logic [3:0]     sticky_clr;
  logic [3:0]     pulse;
  logic [3:0]     sticky;
  logic [3:0]     overrun;

  int n_assert;
  int n_fail;
  int cnt;
  int first;
  int last;
  logic [3:0] others;

  multi_edge_pulse dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .level     (level),
    .mode      (mode),
    .pulse_len (pulse_len),
    .sticky_clr(sticky_clr),
    .pulse     (pulse),
    .sticky    (sticky),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    level      = 4'b0000;
    mode[0]    = EDGE_RISE;
    mode[1]    = EDGE_OFF;
    mode[2]    = EDGE_BOTH;
    mode[3]    = EDGE_OFF;
    pulse_len  = 4'd0;
    sticky_clr = 4'b0000;

    // Reset state
    tick(); tick();
    check("reset_pulse", pulse, 4'b0000);
    check("reset_sticky", sticky, 4'b0000);
    check("reset_overrun", overrun, 4'b0000);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Basic rise on ch0, pulse_len 0
    level[0] = 1'b1;
    tick();
    check("rise_pre", pulse, 4'b0000);
    tick();
    check("rise_pulse", pulse, 4'b0001);
    check("rise_sticky_early", sticky, 4'b0000);
    tick();
    check("rise_pulse_end", pulse, 4'b0000);
    check("rise_sticky", sticky, 4'b0001);
    tick(); tick();

    // Ch1 level rises while OFF, then mode BOTH: no spurious edge
    level[1] = 1'b1;
    tick(); tick(); tick(); tick();
    check("off_no_pulse", pulse, 4'b0000);
    check("off_no_sticky", sticky, 4'b0001);
    mode[1] = EDGE_BOTH;
    tick(); tick(); tick(); tick();
    check("modechg_no_pulse", pulse, 4'b0000);

    // Stretch: single fall on ch1, pulse_len 5; pulse_len change mid-pulse ignored
    pulse_len = 4'd5;
    level[1]  = 1'b0;
    cnt = 0; first = -1; others = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      others = others | (pulse & 4'b1101);
      if (pulse[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == 4) pulse_len = 4'd1;
    end
    check("stretch_len", 32'(cnt), 32'd6);
    check("stretch_start", 32'(first), 32'd2);
    check("stretch_others", others, 4'b0000);
    check("stretch_overrun", overrun, 4'b0000);
    check("stretch_sticky", sticky, 4'b0011);

    // Retrigger on ch2, pulse_len 7, second edge four cycles later
    pulse_len = 4'd7;
    level[2]  = 1'b1;
    cnt = 0; first = -1; last = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pulse[2]) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == 4) level[2] = 1'b0;
    end
    check("retrig_len", 32'(cnt), 32'd12);
    check("retrig_first", 32'(first), 32'd2);
    check("retrig_last", 32'(last), 32'd13);
    check("retrig_overrun", overrun, 4'b0100);
    check("retrig_sticky", sticky, 4'b0111);

    // Mode gating on ch3
    pulse_len = 4'd0;
    level[3]  = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (pulse[3]) cnt++;
      if (i == 4) level[3] = 1'b0;
      if (i == 8) level[3] = 1'b1;
    end
    check("gate_off_pulses", 32'(cnt), 32'd0);
    check("gate_off_sticky", sticky, 4'b0111);
    mode[3] = EDGE_FALL;
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (pulse[3]) cnt++;
    end
    check("gate_steady_pulses", 32'(cnt), 32'd0);
    level[3] = 1'b0;
    cnt = 0; first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (pulse[3]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("gate_fall_len", 32'(cnt), 32'd1);
    check("gate_fall_first", 32'(first), 32'd2);
    check("gate_fall_sticky", sticky, 4'b1111);

    // Clear of sticky and overrun
    sticky_clr = 4'b0101;
    tick();
    sticky_clr = 4'b0000;
    check("clr_sticky", sticky, 4'b1010);
    check("clr_overrun", overrun, 4'b0000);

    // Sticky set wins over simultaneous clear on ch0
    level[0] = 1'b0;
    tick(); tick(); tick(); tick();
    check("fall_in_rise_mode", pulse, 4'b0000);
    check("fall_in_rise_sticky", sticky, 4'b1010);
    level[0] = 1'b1;
    tick();
    tick();
    check("prio_pulse", pulse, 4'b0001);
    sticky_clr = 4'b0001;
    tick();
    check("prio_set_wins", sticky, 4'b1011);
    tick();
    check("prio_clear_alone", sticky, 4'b1010);
    sticky_clr = 4'b0000;
    tick();

    // Reset mid-pulse on ch1, pulse_len 15
    pulse_len = 4'd15;
    level[1]  = 1'b1;
    tick();
    tick();
    check("rst_pulse_c1", pulse, 4'b0010);
    tick();
    check("rst_pulse_c2", pulse, 4'b0010);
    tick();
    check("rst_pulse_c3", pulse, 4'b0010);
    reset_n   = 1'b0;
    pulse_len = 4'd0;
    #1;
    check("rst_async_pulse", pulse, 4'b0000);
    check("rst_async_sticky", sticky, 4'b0000);
    check("rst_async_overrun", overrun, 4'b0000);
    tick(); tick();
    check("rst_hold_pulse", pulse, 4'b0000);
    reset_n = 1'b1;
    tick();
    check("rel_pre", pulse, 4'b0000);
    tick();
    check("rel_pulse", pulse, 4'b0011);
    tick();
    check("rel_pulse_end", pulse, 4'b0000);
    check("rel_sticky", sticky, 4'b0011);
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (pulse != 4'b0000) cnt++;
    end
    check("rel_no_resume", 32'(cnt), 32'd0);
    check("rel_overrun", overrun, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
